// File: rtl/dmem_responder_pkg.sv
// Shared encodings for the data-memory responder: RV32I load/store funct3
// codes, FSM states, and the byte-lane helpers used by both load and store paths.
package dmem_responder_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic [3:0] store_byte_en(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B:    store_byte_en = 4'b0001 << off;
      F3_H:    store_byte_en = off[1] ? 4'b1100 : 4'b0011;
      default: store_byte_en = 4'b1111;
    endcase
  endfunction

  // Data is replicated across lanes so the byte enables alone pick the target.
  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] w);
    case (f3)
      F3_B:    store_lanes = {4{w[7:0]}};
      F3_H:    store_lanes = {2{w[15:0]}};
      default: store_lanes = w;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      F3_B:    load_extend = {{24{b[7]}}, b};
      F3_BU:   load_extend = {24'd0, b};
      F3_H:    load_extend = {{16{h[15]}}, h};
      F3_HU:   load_extend = {16'd0, h};
      default: load_extend = w;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// Contents are deliberately not reset.
module dmem_ram #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [0:(1 << ADDR_WIDTH) - 1];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data memory responder: one outstanding request, loads answer two
// cycles after acceptance, stores and faulting accesses one cycle after.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall_req,
  output logic [1:0]  state_dbg
);

  // Handshake: a request moves on a rising edge where req_valid & req_ready;
  // a response completes on a rising edge where resp_valid & resp_ready, and
  // resp_* hold stable from assertion until that edge.

  state_t      state;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_off;
  logic [31:0] offset;
  logic        in_range;
  logic        funct_ok;
  logic        misalign;
  logic        req_err;
  logic        fire;
  logic [31:0] ram_rdata;

  assign offset   = req_addr - BASE_ADDR;
  assign in_range = (req_addr >= BASE_ADDR) && ((offset >> (ADDR_WIDTH + 2)) == 32'd0);
  assign funct_ok = req_we ? (req_funct3 <= F3_W)
                           : (req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  assign misalign = ((req_funct3[1:0] == 2'd1) && req_addr[0])
                 || ((req_funct3[1:0] == 2'd2) && (req_addr[1:0] != 2'd0));
  assign req_err  = ~funct_ok | misalign | ~in_range;

  assign req_ready = (state == ST_IDLE);
  assign fire      = req_valid & req_ready;
  assign stall_req = req_valid & ~(resp_valid & resp_ready);
  assign state_dbg = state;

  // The RAM sees the request directly, so stores land and loads launch on the acceptance edge.
  dmem_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk   (clk),
    .en    (fire & ~req_err),
    .we    (req_we),
    .be    (store_byte_en(req_funct3, req_addr[1:0])),
    .addr  (offset[ADDR_WIDTH+1:2]),
    .wdata (store_lanes(req_funct3, req_wdata)),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      ld_funct3  <= 3'd0;
      ld_off     <= 2'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fire) begin
            ld_funct3 <= req_funct3;
            ld_off    <= req_addr[1:0];
            if (req_err || req_we) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= req_err;
              resp_rdata <= 32'd0;
            end else begin
              state <= ST_READ;
            end
          end
        end
        ST_READ: begin
          state      <= ST_RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= load_extend(ld_funct3, ld_off, ram_rdata);
        end
        ST_RESP: begin
          if (resp_ready) begin
            state      <= ST_IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
